combat_arbiter: RTL

- Frame-rate damage arbiter between the two fighters.
- Collects the per-pixel hit indications produced during a frame: melee sprite overlap, fireball on player 2, and fireball on player 1.
- At each frame boundary, decides which attacks landed, applies block reduction and hit-stun, and updates both health values.
- Drives health-bar lengths and KO flags for the colour mapper and the round-flow logic. It replaces the two free-running per-pixel health counters.

---
 rtl/combat_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/combat_arbiter.sv
// Frame-rate damage arbiter: gathers per-pixel hit evidence during a frame, resolves damage,
// block, hit-stun and KO once per frame boundary, and drives both health bars.
module combat_arbiter #(
  parameter int unsigned MAX_HEALTH     = 200,
  parameter int unsigned PUNCH_DMG      = 10,
  parameter int unsigned KICK_DMG       = 15,
  parameter int unsigned BALL_DMG       = 25,
  parameter int unsigned BLOCK_SHIFT    = 2,
  parameter int unsigned HITSTUN_FRAMES = 20
) (
  input  logic       pixel_Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       start,
  input  logic       collision,
  input  logic       ballcollision,
  input  logic       ballcollision2,
  input  logic       punch,
  input  logic       kick,
  input  logic       crouchpunch,
  input  logic       punch2,
  input  logic       kick2,
  input  logic       crouchpunch2,
  input  logic       block,
  input  logic       block2,
  output logic [7:0] health1,
  output logic [7:0] health2,
  output logic       ko1,
  output logic       ko2,
  output logic       stun1,
  output logic       stun2,
  output logic       hit_pulse
);

  localparam int unsigned StunW = (HITSTUN_FRAMES < 2) ? 1 : $clog2(HITSTUN_FRAMES + 1);
  localparam logic [8:0] PunchD = 9'(PUNCH_DMG);
  localparam logic [8:0] KickD  = 9'(KICK_DMG);
  localparam logic [8:0] BallD  = 9'(BALL_DMG);
  localparam logic [7:0] MaxH   = 8'(MAX_HEALTH);
  localparam logic [StunW-1:0] StunLoad = StunW'(HITSTUN_FRAMES);
  localparam logic [StunW-1:0] StunOne  = StunW'(1);

  typedef enum logic [1:0] {StIdle, StFight, StKo} state_e;

  state_e r_state, w_state_next;
  logic   w_active, w_reload, w_idle, w_capture, w_apply;

  logic r_melee, r_ball1, r_ball2, r_p1_kick, r_p1_punch, r_p2_kick, r_p2_punch;
  logic r_e_melee, r_e_ball1, r_e_ball2, r_e_p1_kick, r_e_p1_punch, r_e_p2_kick, r_e_p2_punch;
  logic r_pending, r_hit, r_ko1, r_ko2;
  logic [7:0] r_health1, r_health2;
  logic [StunW-1:0] r_stun1, r_stun2;

  logic [8:0] w_melee1, w_melee2, w_raw1, w_raw2, w_blk1, w_blk2, w_dmg1, w_dmg2;
  logic [7:0] w_new_h1, w_new_h2;

  // FSM: state register
  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StFight;
      StFight: begin
        if (!start)             w_state_next = StIdle;
        else if (r_ko1 || r_ko2) w_state_next = StKo;
      end
      StKo:    if (!start) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    w_idle   = (r_state == StIdle);
    w_reload = w_idle && start;
    w_active = (r_state == StFight) && start;
  end

  assign w_capture = w_active && frame_start;
  assign w_apply   = w_active && r_pending;

  // Accumulators; inputs seen on the boundary cycle seed the next frame.
  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      {r_melee, r_ball1, r_ball2, r_p1_kick, r_p1_punch, r_p2_kick, r_p2_punch} <= '0;
      {r_e_melee, r_e_ball1, r_e_ball2, r_e_p1_kick, r_e_p1_punch, r_e_p2_kick,
       r_e_p2_punch} <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_capture;
      if (w_capture) begin
        {r_e_melee, r_e_ball1, r_e_ball2} <= {r_melee, r_ball1, r_ball2};
        {r_e_p1_kick, r_e_p1_punch, r_e_p2_kick, r_e_p2_punch} <=
            {r_p1_kick, r_p1_punch, r_p2_kick, r_p2_punch};
        {r_melee, r_ball1, r_ball2} <= {collision, ballcollision, ballcollision2};
        {r_p1_kick, r_p1_punch} <= {kick, punch | crouchpunch};
        {r_p2_kick, r_p2_punch} <= {kick2, punch2 | crouchpunch2};
      end else if (w_active) begin
        r_melee    <= r_melee | collision;
        r_ball1    <= r_ball1 | ballcollision;
        r_ball2    <= r_ball2 | ballcollision2;
        r_p1_kick  <= r_p1_kick | kick;
        r_p1_punch <= r_p1_punch | punch | crouchpunch;
        r_p2_kick  <= r_p2_kick | kick2;
        r_p2_punch <= r_p2_punch | punch2 | crouchpunch2;
      end else begin
        {r_melee, r_ball1, r_ball2, r_p1_kick, r_p1_punch, r_p2_kick, r_p2_punch} <= '0;
      end
    end
  end

  // Damage resolution for the frame just captured; kick beats punch.
  always_comb begin
    w_melee2 = '0;
    if (r_e_melee && r_e_p1_kick)       w_melee2 = KickD;
    else if (r_e_melee && r_e_p1_punch) w_melee2 = PunchD;
    w_melee1 = '0;
    if (r_e_melee && r_e_p2_kick)       w_melee1 = KickD;
    else if (r_e_melee && r_e_p2_punch) w_melee1 = PunchD;
    w_raw2   = w_melee2 + (r_e_ball1 ? BallD : 9'd0);
    w_raw1   = w_melee1 + (r_e_ball2 ? BallD : 9'd0);
    w_blk2   = block2 ? (w_raw2 >> BLOCK_SHIFT) : w_raw2;
    w_blk1   = block  ? (w_raw1 >> BLOCK_SHIFT) : w_raw1;
    w_dmg2   = (r_stun2 != '0) ? 9'd0 : w_blk2;
    w_dmg1   = (r_stun1 != '0) ? 9'd0 : w_blk1;
    w_new_h2 = (w_dmg2 >= {1'b0, r_health2}) ? 8'd0 : (r_health2 - w_dmg2[7:0]);
    w_new_h1 = (w_dmg1 >= {1'b0, r_health1}) ? 8'd0 : (r_health1 - w_dmg1[7:0]);
  end

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      r_health1 <= MaxH;
      r_health2 <= MaxH;
      r_ko1     <= 1'b0;
      r_ko2     <= 1'b0;
      r_stun1   <= '0;
      r_stun2   <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_hit <= w_apply && ((w_dmg1 != 9'd0) || (w_dmg2 != 9'd0));
      if (w_reload) begin
        r_health1 <= MaxH;
        r_health2 <= MaxH;
        r_ko1     <= 1'b0;
        r_ko2     <= 1'b0;
        r_stun1   <= '0;
        r_stun2   <= '0;
      end else if (w_idle) begin
        r_health1 <= MaxH;
        r_health2 <= MaxH;
      end else if (w_apply) begin
        r_health1 <= w_new_h1;
        r_health2 <= w_new_h2;
        if (w_new_h1 == 8'd0) r_ko1 <= 1'b1;
        if (w_new_h2 == 8'd0) r_ko2 <= 1'b1;
        if (w_dmg1 != 9'd0) r_stun1 <= StunLoad;
        if (w_dmg2 != 9'd0) r_stun2 <= StunLoad;
      end else if (w_capture) begin
        if (r_stun1 != '0) r_stun1 <= r_stun1 - StunOne;
        if (r_stun2 != '0) r_stun2 <= r_stun2 - StunOne;
      end
    end
  end

  assign health1   = r_health1;
  assign health2   = r_health2;
  assign ko1       = r_ko1;
  assign ko2       = r_ko2;
  assign stun1     = (r_stun1 != '0);
  assign stun2     = (r_stun2 != '0);
  assign hit_pulse = r_hit;

endmodule
